// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 active-low keypad matrix model.
// row_drive is reusable by any bench that needs to predict the matrix response.
package keypad_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BOUNCE_IN  = 3'd1,
    S_HOLD       = 3'd2,
    S_BOUNCE_OUT = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  localparam logic [2:0] LOC_NONE = 3'b100;

  localparam logic [3:0] COL_0 = 4'b1110;
  localparam logic [3:0] COL_1 = 4'b1101;
  localparam logic [3:0] COL_2 = 4'b1011;
  localparam logic [3:0] COL_3 = 4'b0111;

  // Pull the addressed row low only while the contact is closed and its column is driven.
  function automatic logic [3:0] row_drive(input logic       contact,
                                           input logic [2:0] loc_row,
                                           input logic [2:0] loc_col,
                                           input logic [3:0] col);
    logic [3:0] rows;
    rows = 4'b1111;
    if (contact && !loc_row[2] && !loc_col[2] && !col[loc_col[1:0]]) begin
      rows[loc_row[1:0]] = 1'b0;
    end
    return rows;
  endfunction

endpackage

// File: rtl/keypad_matrix_model.sv
// Timed press model of a 4x4 active-low key matrix: closes one contact with optional
// make/break bounce and answers the scanner's column drive on row_b.
module keypad_matrix_model
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned BOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [2:0] key_row,
  input  logic [2:0] key_col,
  input  logic [3:0] col,
  output logic [3:0] row_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] press_count
);

  localparam int unsigned MAX_HB     = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic             HAS_BOUNCE  = (BOUNCE_CYCLES != 0);
  localparam logic             B_ODD       = 1'(BOUNCE_CYCLES % 2);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       loc_row;
  logic [2:0]       loc_col;
  logic             contact;
  logic             contact_d;
  logic             done_d;
  logic             accept;

  assign accept = key_valid && (state == S_IDLE);

  // State, counter, contact and location registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      contact     <= 1'b0;
      loc_row     <= LOC_NONE;
      loc_col     <= LOC_NONE;
      done        <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state       <= state_d;
      phase_cnt   <= cnt_d;
      contact     <= contact_d;
      done        <= done_d;
      press_count <= press_count + 8'(done_d);
      if (accept) begin
        loc_row <= key_row;
        loc_col <= key_col;
      end
    end
  end

  // Next state; contact is derived from where the sequence will be next cycle
  always_comb begin
    state_d   = state;
    cnt_d     = phase_cnt;
    done_d    = 1'b0;
    contact_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (key_valid) begin
          if (HAS_BOUNCE) begin
            state_d = S_BOUNCE_IN;
            cnt_d   = BOUNCE_LOAD;
          end else begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      S_BOUNCE_IN: begin
        if (phase_cnt == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = phase_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (phase_cnt == '0) begin
          if (HAS_BOUNCE) begin
            state_d = S_BOUNCE_OUT;
            cnt_d   = BOUNCE_LOAD;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = phase_cnt - CNT_W'(1);
        end
      end
      S_BOUNCE_OUT: begin
        if (phase_cnt == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = phase_cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (phase_cnt == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = phase_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Bounce index k = BOUNCE_CYCLES - cnt, so its parity is B_ODD ^ cnt[0]
    case (state_d)
      S_BOUNCE_IN:  contact_d = B_ODD ^ cnt_d[0];
      S_HOLD:       contact_d = 1'b1;
      S_BOUNCE_OUT: contact_d = ~(B_ODD ^ cnt_d[0]);
      default:      contact_d = 1'b0;
    endcase
  end

  // Handshake status and zero-latency row response
  always_comb begin
    key_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    row_b     = row_drive(contact, loc_row, loc_col, col);
  end

endmodule

// File: tb/tb_keypad_matrix_model.sv
// Directed bench for keypad_matrix_model: one instance without bounce, one with bounce 4,
// plus a tiny rotating column scanner that reports the first row/column it sees pressed.
module tb_keypad_matrix_model;
  import keypad_pkg::*;

  logic       clk;
  logic       rst;
  logic       valid0;
  logic       valid4;
  logic [2:0] key_row;
  logic [2:0] key_col;
  logic [3:0] col;
  logic       scan_en;
  logic [3:0] col_force;
  logic [1:0] scan;
  logic [2:0] scan_row;
  logic [2:0] scan_col;

  logic       ready0, busy0, done0;
  logic [3:0] row_b0;
  logic [7:0] count0;
  logic       ready4, busy4, done4;
  logic [3:0] row_b4;
  logic [7:0] count4;

  int total;
  int bad;

  keypad_matrix_model #(.HOLD_CYCLES(16), .BOUNCE_CYCLES(0), .GAP_CYCLES(8)) dut0 (
    .clk(clk), .rst(rst), .key_valid(valid0), .key_ready(ready0), .key_row(key_row),
    .key_col(key_col), .col(col), .row_b(row_b0), .busy(busy0), .done(done0),
    .press_count(count0)
  );

  keypad_matrix_model #(.HOLD_CYCLES(16), .BOUNCE_CYCLES(4), .GAP_CYCLES(8)) dut4 (
    .clk(clk), .rst(rst), .key_valid(valid4), .key_ready(ready4), .key_row(key_row),
    .key_col(key_col), .col(col), .row_b(row_b4), .busy(busy4), .done(done4),
    .press_count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) scan <= scan + 2'd1;

  always_comb col = scan_en ? ~(4'b0001 << scan) : col_force;

  // Scanner stand-in watching the no-bounce instance
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      scan_row <= LOC_NONE;
      scan_col <= LOC_NONE;
    end else if (scan_en && row_b0 != 4'b1111) begin
      for (int i = 0; i < 4; i++) if (!row_b0[i]) scan_row <= 3'(i);
      scan_col <= {1'b0, scan};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived contact for bounce 4 / hold 16 / gap 8, cycle k after accept
  function automatic logic exp_contact(input int k);
    if (k <= 4) return (k % 2) == 1;
    if (k <= 20) return 1'b1;
    if (k <= 24) return (k % 2) == 0;
    return 1'b0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (row_b0 !== 4'b1111) begin bad++; $display("FAIL reset_row_b0 got=%b exp=1111", row_b0); end
    total++; if (row_b4 !== 4'b1111) begin bad++; $display("FAIL reset_row_b4 got=%b exp=1111", row_b4); end
    total++; if (ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      bad++; $display("FAIL reset_hs0 ready=%b busy=%b done=%b exp=1,0,0", ready0, busy0, done0); end
    total++; if (ready4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++; $display("FAIL reset_hs4 ready=%b busy=%b done=%b exp=1,0,0", ready4, busy4, done4); end
    total++; if (count0 !== 8'd0 || count4 !== 8'd0) begin
      bad++; $display("FAIL reset_count got=%0d,%0d exp=0,0", count0, count4); end
    rst = 1'b0;
    scan_en = 1'b1;
    repeat (8) tick();
    total++; if (scan_row !== 3'b100 || scan_col !== 3'b100) begin
      bad++; $display("FAIL idle_scan got=%b,%b exp=100,100", scan_row, scan_col); end
    total++; if (row_b0 !== 4'b1111 || ready0 !== 1'b1) begin
      bad++; $display("FAIL idle_row0 row_b=%b ready=%b exp=1111,1", row_b0, ready0); end
  endtask

  task automatic test_press_no_bounce();
    int errs;
    logic [3:0] exp_rows;
    errs = 0;
    key_row = 3'd2; key_col = 3'd1; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      exp_rows = (k <= 16 && col == 4'b1101) ? 4'b1011 : 4'b1111;
      total++;
      if (row_b0 !== exp_rows || busy0 !== 1'b1 || done0 !== 1'b0) begin
        bad++;
        $display("FAIL nb_cycle%0d row_b=%b busy=%b done=%b exp=%b,1,0", k, row_b0, busy0, done0, exp_rows);
      end
      tick();
    end
    total++; if (done0 !== 1'b1 || ready0 !== 1'b1) begin
      bad++; $display("FAIL nb_done done=%b ready=%b exp=1,1", done0, ready0); end
    total++; if (count0 !== 8'd1) begin bad++; $display("FAIL nb_count got=%0d exp=1", count0); end
    total++; if (scan_row !== 3'b010 || scan_col !== 3'b001) begin
      bad++; $display("FAIL nb_scan got=%b,%b exp=010,001", scan_row, scan_col); end
    tick();
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL nb_done_pulse got=%b exp=0", done0); end
    scan_en = 1'b0;
  endtask

  task automatic test_bounce();
    logic [3:0] exp_rows;
    key_row = 3'd3; key_col = 3'd0; col_force = COL_0; valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      exp_rows = exp_contact(k) ? 4'b0111 : 4'b1111;
      total++;
      if (row_b4 !== exp_rows || done4 !== 1'b0) begin
        bad++; $display("FAIL bounce_cycle%0d row_b=%b done=%b exp=%b,0", k, row_b4, done4, exp_rows);
      end
      tick();
    end
    total++; if (done4 !== 1'b1 || count4 !== 8'd1) begin
      bad++; $display("FAIL bounce_done done=%b count=%0d exp=1,1", done4, count4); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rows;
    key_row = 3'd1; key_col = 3'd2; col_force = COL_2; valid4 = 1'b1;
    tick();
    for (int k = 1; k <= 32; k++) begin
      if (k == 10) begin key_row = 3'd0; key_col = 3'd3; end
      exp_rows = exp_contact(k) ? 4'b1101 : 4'b1111;
      total++;
      if (row_b4 !== exp_rows) begin
        bad++; $display("FAIL b2b_first_cycle%0d row_b=%b exp=%b", k, row_b4, exp_rows);
      end
      tick();
    end
    total++; if (done4 !== 1'b1 || ready4 !== 1'b1 || count4 !== 8'd2) begin
      bad++; $display("FAIL b2b_first_done done=%b ready=%b count=%0d exp=1,1,2", done4, ready4, count4); end
    col_force = COL_3;
    tick();
    total++; if (busy4 !== 1'b1 || done4 !== 1'b0 || row_b4 !== 4'b1110) begin
      bad++; $display("FAIL b2b_second_accept busy=%b done=%b row_b=%b exp=1,0,1110", busy4, done4, row_b4); end
    valid4 = 1'b0;
    tick();
    for (int k = 2; k <= 32; k++) begin
      exp_rows = exp_contact(k) ? 4'b1110 : 4'b1111;
      total++;
      if (row_b4 !== exp_rows) begin
        bad++; $display("FAIL b2b_second_cycle%0d row_b=%b exp=%b", k, row_b4, exp_rows);
      end
      tick();
    end
    total++; if (done4 !== 1'b1 || count4 !== 8'd3) begin
      bad++; $display("FAIL b2b_second_done done=%b count=%0d exp=1,3", done4, count4); end
    tick();
  endtask

  task automatic test_no_key();
    key_row = LOC_NONE; key_col = 3'd0; col_force = COL_0; valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      total++;
      if (row_b4 !== 4'b1111 || busy4 !== 1'b1 || done4 !== 1'b0) begin
        bad++; $display("FAIL nokey_cycle%0d row_b=%b busy=%b done=%b exp=1111,1,0", k, row_b4, busy4, done4);
      end
      tick();
    end
    total++; if (done4 !== 1'b1 || count4 !== 8'd4) begin
      bad++; $display("FAIL nokey_done done=%b count=%0d exp=1,4", done4, count4); end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    key_row = 3'd2; key_col = 3'd0; col_force = COL_0; valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
    repeat (7) tick();
    total++; if (row_b4 !== 4'b1011) begin bad++; $display("FAIL rstmid_hold row_b=%b exp=1011", row_b4); end
    rst = 1'b1;
    #1;
    total++; if (row_b4 !== 4'b1111) begin bad++; $display("FAIL rstmid_row row_b=%b exp=1111", row_b4); end
    total++; if (ready4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++; $display("FAIL rstmid_hs ready=%b busy=%b done=%b exp=1,0,0", ready4, busy4, done4); end
    total++; if (count4 !== 8'd0 || count0 !== 8'd0) begin
      bad++; $display("FAIL rstmid_count got=%0d,%0d exp=0,0", count4, count0); end
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (done4 !== 1'b0 || ready4 !== 1'b1 || row_b4 !== 4'b1111) pulses++;
      tick();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_quiet got=%0d bad cycles exp=0", pulses); end
  endtask

  task automatic test_count_wrap();
    int n;
    key_row = 3'd0; key_col = 3'd0; valid0 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      n = 1;
      while (!done0 && n < 40) begin tick(); n++; end
      if (i == 255) valid0 = 1'b0;
      total++;
      if (done0 !== 1'b1) begin
        bad++; $display("FAIL wrap_timeout press=%0d done=%b exp=1", i, done0);
        valid0 = 1'b0;
        break;
      end
      total++;
      if (count0 !== 8'(i + 1)) begin
        bad++; $display("FAIL wrap_count press=%0d got=%0d exp=%0d", i, count0, 8'(i + 1));
      end
    end
    valid0 = 1'b0;
    total++; if (count0 !== 8'd0) begin bad++; $display("FAIL wrap_final got=%0d exp=0", count0); end
    tick();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; valid0 = 1'b0; valid4 = 1'b0;
    key_row = LOC_NONE; key_col = LOC_NONE;
    scan_en = 1'b0; col_force = 4'b1111; scan = 2'd0;
    test_reset();
    test_press_no_bounce();
    test_bounce();
    test_back_to_back();
    test_no_key();
    test_reset_mid();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_model.md
# keypad_matrix_model

Behavioural-but-synthesizable model of a 4x4 active-low key matrix: the far end of the keyboard scanner's column/row interface. It accepts press requests (row/column location plus handshake), closes the addressed contact for a programmed time with optional contact bounce on make and break, and drives `row_b` in response to the scanner's column drive. It sits in the simulation project between the stimulus layer and the keyboard scanner, replacing the physical keypad.

## Interface
- `HOLD_CYCLES`, 16: cycles the contact stays solidly closed; must be ≥1.
- `BOUNCE_CYCLES`, 4: bounce cycles on make and again on break; 0 disables bounce.
- `GAP_CYCLES`, 8: solidly open cycles after break before the next request is accepted; must be ≥1.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_valid` in 1: press request valid.
- `key_ready` out 1: model idle; request accepted when `key_valid && key_ready` at a rising edge.
- `key_row` in 3: row location, 0–3; bit 2 set means "no key".
- `key_col` in 3: column location, same encoding.
- `col` in 4: column drive from the scanner; active-low.
- `row_b` out 4: row sense to the scanner; active-low, idle 4'b1111.
- `busy` out 1: press sequence in progress (= !`key_ready`).
- `done` out 1: one-cycle pulse when a sequence finishes.
- `press_count` out 8: completed sequences, wraps 255→0.

## Operation
- States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP. One down-counter `phase_cnt` (width covers the largest parameter), plus latched `loc_row`, `loc_col`, and registered `contact`.
- IDLE: `key_ready`=1, `contact`=0. On accept, latch the location, load the counter, and go to BOUNCE_IN (or to HOLD if `BOUNCE_CYCLES`=0).
- BOUNCE_IN: `contact` is closed on the 1st, 3rd, 5th… cycle and open on even cycles. After `BOUNCE_CYCLES` cycles, go to HOLD.
- HOLD: `contact`=1 for `HOLD_CYCLES` cycles, then BOUNCE_OUT (or GAP if no bounce).
- BOUNCE_OUT: `contact` is open on the 1st, 3rd… cycle and closed on even cycles, for `BOUNCE_CYCLES` cycles, then GAP.
- GAP: `contact`=0 for `GAP_CYCLES` cycles, then IDLE.
- On GAP→IDLE: `done` pulses and `press_count` increments.
- Row drive is combinational:
  - `row_b[loc_row]` = 0 iff `contact` && `col[loc_col]`==0 && `loc_row[2]`==0 && `loc_col[2]`==0.
  - All other `row_b` bits = 1.
  - The scanner's `col` depends only on its counter, so there is no combinational loop.
- "No key" locations are accepted and run the full timed sequence, but `row_b` stays 4'b1111 throughout.
- `key_valid` while busy is ignored; the request is not queued.
- Changes on `key_row`/`key_col` while busy have no effect; the latched location is used.

## Timing
- Reset values: state IDLE, `contact` 0, `row_b` 4'b1111, `key_ready` 1, `busy` 0, `done` 0, `press_count` 0, latched location 3'b100.
- Accept at edge N. The first bounce or hold cycle is the cycle after edge N; `contact` is registered.
- Accept to `done` = 2·`BOUNCE_CYCLES` + `HOLD_CYCLES` + `GAP_CYCLES` cycles. `done` is high in the cycle `key_ready` returns to 1.
- Back-to-back: a request held high through `done` is accepted at the edge ending the `done` cycle.
- `row_b` follows `col` with zero latency.
- Reset mid-sequence: the contact opens immediately, `row_b`=4'b1111, no `done`, and `press_count` is cleared.

## Structure
- Package `keypad_pkg`:
  - state enum;
  - `LOC_NONE` = 3'b100;
  - column one-hot-low patterns 4'b1110/1101/1011/0111;
  - function `row_drive(contact, loc_row, loc_col, col)`.
- Single module; no sub-module. The row-drive function lives in the package so the scanner bench can reuse it.

## Test plan
- Reset then idle with scanner attached: `row_b`=4'b1111, scanner reports row/col location 3'b100, `key_ready`=1.
- Press row 2 / col 1 with bounce 0, hold 16, gap 8:
  - `row_b`=4'b1011 exactly when `col`=4'b1101 during HOLD;
  - scanner reports (3'b010, 3'b001);
  - `done` at 24 cycles after accept; `press_count`=1.
- Bounce 4: `contact` pattern 1,0,1,0 then 16×1 then 0,1,0,1 then 8×0; `done` at 32 cycles.
- `key_valid` held high across two sequences with new locations: second accept on the `done` edge; the mid-sequence location change is ignored.
- "No key" request (`key_row`=3'b100): `row_b` stays 4'b1111 for the whole sequence; `done` still pulses at the computed cycle.
- Assert `rst` during HOLD: `row_b`=4'b1111 in the same cycle, `key_ready`=1, `press_count`=0, no `done`. Also run 256 presses and check `press_count` wraps to 0.
